// File: rtl/serial_loader_pkg.sv
// Shared types and constants for the serial byte loader.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    LOAD
  } loader_state_t;

  localparam int unsigned LOADER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_byte_loader_shift_in_reg.sv
// Parameterised serial-in shift register with enable, direction select and async clear.
// o_q_next exposes the value the register will take at the next edge.
module shift_in_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] r_q;

  // MSB-first fills from the LSB end so the first bit ends up in the MSB.
  always_comb begin
    o_q_next = r_q;
    if (i_shift_en) begin
      if (MSB_FIRST) o_q_next = {r_q[WIDTH-2:0], i_bit};
      else           o_q_next = {i_bit, r_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= o_q_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_byte_loader.sv
// Assembles a framed serial bit stream into a word, optionally checks even parity,
// and presents it to the downstream register with a one-cycle load strobe.
module serial_byte_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = LOADER_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             abort,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic             busy,
  output logic             par_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  loader_state_t    r_state;
  loader_state_t    w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept_data;
  logic             w_last_data;
  logic             w_accept_par;
  logic             w_enter_load;

  assign w_accept_data = (r_state == SHIFT) && din_valid && !abort;
  assign w_last_data   = w_accept_data && (r_cnt == CW'(WIDTH - 1));
  assign w_accept_par  = (r_state == PARITY) && din_valid && !abort;
  assign w_enter_load  = PARITY_EN ? w_accept_par : w_last_data;

  shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (reset),
    .i_shift_en (w_accept_data),
    .i_bit      (din),
    .o_q        (w_q),
    .o_q_next   (w_q_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_state_next = SHIFT;
      SHIFT: begin
        if (abort)            w_state_next = IDLE;
        else if (w_last_data) w_state_next = PARITY_EN ? PARITY : LOAD;
      end
      PARITY: begin
        if (abort)          w_state_next = IDLE;
        else if (din_valid) w_state_next = LOAD;
      end
      LOAD:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Counter and parity accumulator are held clear in IDLE, so they restart on every frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (w_accept_data) begin
      r_cnt <= r_cnt + 1'b1;
      r_par <= r_par ^ din;
    end
  end

  // Without parity the last data bit shifts in on the same edge, hence the look-ahead value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out   <= '0;
      par_err <= 1'b0;
    end else if (w_enter_load) begin
      d_out   <= (r_state == PARITY) ? w_q : w_q_next;
      par_err <= PARITY_EN ? (r_par ^ din) : 1'b0;
    end
  end

  assign en_out = (r_state == LOAD);
  assign busy   = (r_state == SHIFT) || (r_state == PARITY);

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench: instance A is MSB-first with parity, instance B is LSB-first without.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_start = 1'b0, a_din = 1'b0, a_vld = 1'b0, a_abort = 1'b0;
  logic       b_start = 1'b0, b_din = 1'b0, b_vld = 1'b0, b_abort = 1'b0;
  logic [7:0] a_dout, b_dout;
  logic       a_en, a_busy, a_perr;
  logic       b_en, b_busy, b_perr;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .din(a_din), .din_valid(a_vld),
    .abort(a_abort), .d_out(a_dout), .en_out(a_en), .busy(a_busy), .par_err(a_perr)
  );

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .din(b_din), .din_valid(b_vld),
    .abort(b_abort), .d_out(b_dout), .en_out(b_en), .busy(b_busy), .par_err(b_perr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start plus 8 data bits MSB first plus parity, din_valid held high; returns in the strobe cycle.
  task automatic send_a(input logic [7:0] data, input logic par);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      a_din = data[i];
      a_vld = 1'b1;
      step();
    end
    a_din = par;
    step();
    a_vld = 1'b0;
    a_din = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_a_dout got=%h exp=00", a_dout); end
    total++; if ({a_en, a_busy, a_perr} !== 3'b000) begin bad++; $display("FAIL reset_a_flags got=%b exp=000", {a_en, a_busy, a_perr}); end
    total++; if (b_dout !== 8'h00) begin bad++; $display("FAIL reset_b_dout got=%h exp=00", b_dout); end
    total++; if ({b_en, b_busy, b_perr} !== 3'b000) begin bad++; $display("FAIL reset_b_flags got=%b exp=000", {b_en, b_busy, b_perr}); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_frame_msb_par();
    logic [7:0] data;
    int cyc;
    int strobe_at;
    data = 8'hA5;
    cyc = 0;
    strobe_at = -1;
    a_start = 1'b1;
    step();
    cyc = 1;
    a_start = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL frame_busy_after_start got=%b exp=1", a_busy); end
    for (int i = 7; i >= 0; i--) begin
      a_din = data[i];
      a_vld = 1'b1;
      step();
      cyc++;
      if (a_en === 1'b1 && strobe_at < 0) strobe_at = cyc;
    end
    a_din = 1'b0;
    step();
    cyc++;
    if (a_en === 1'b1 && strobe_at < 0) strobe_at = cyc;
    a_vld = 1'b0;
    total++; if (strobe_at !== 10) begin bad++; $display("FAIL frame_latency got=%0d exp=10", strobe_at); end
    total++; if (a_dout !== 8'hA5) begin bad++; $display("FAIL frame_dout got=%h exp=a5", a_dout); end
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL frame_perr got=%b exp=0", a_perr); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL frame_busy_at_strobe got=%b exp=0", a_busy); end
    step();
    total++; if (a_en !== 1'b0) begin bad++; $display("FAIL frame_strobe_width got=%b exp=0", a_en); end
    total++; if (a_dout !== 8'hA5) begin bad++; $display("FAIL frame_dout_hold got=%h exp=a5", a_dout); end
  endtask

  task automatic test_parity_error();
    send_a(8'hA5, 1'b1);
    total++; if (a_en !== 1'b1) begin bad++; $display("FAIL perr_strobe got=%b exp=1", a_en); end
    total++; if (a_dout !== 8'hA5) begin bad++; $display("FAIL perr_dout got=%h exp=a5", a_dout); end
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL perr_flag got=%b exp=1", a_perr); end
    step();
    total++; if (a_en !== 1'b0) begin bad++; $display("FAIL perr_strobe_end got=%b exp=0", a_en); end
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] data;
    int nstrobe;
    logic en_at_last;
    data = 8'h03;
    nstrobe = 0;
    en_at_last = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_din = data[i];
      b_vld = 1'b1;
      step();
      b_vld = 1'b0;
      b_din = 1'b1;
      if (b_en === 1'b1) nstrobe++;
      if (i == 7) en_at_last = b_en;
      if (i != 7) begin
        for (int g = 0; g < 2; g++) begin
          step();
          if (b_en === 1'b1) nstrobe++;
        end
      end
    end
    total++; if (en_at_last !== 1'b1) begin bad++; $display("FAIL lsb_strobe_after_8th got=%b exp=1", en_at_last); end
    total++; if (b_dout !== 8'h03) begin bad++; $display("FAIL lsb_dout got=%h exp=03", b_dout); end
    total++; if (b_perr !== 1'b0) begin bad++; $display("FAIL lsb_perr got=%b exp=0", b_perr); end
    for (int g = 0; g < 3; g++) begin
      step();
      if (b_en === 1'b1) nstrobe++;
    end
    b_din = 1'b0;
    total++; if (nstrobe !== 1) begin bad++; $display("FAIL lsb_strobe_count got=%0d exp=1", nstrobe); end
    total++; if (b_dout !== 8'h03) begin bad++; $display("FAIL lsb_dout_hold got=%h exp=03", b_dout); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] data;
    data = 8'h5A;
    a_start = 1'b1;
    a_din = 1'b1;
    a_vld = 1'b1;
    step();
    for (int i = 7; i >= 0; i--) begin
      a_din = data[i];
      a_vld = 1'b1;
      a_start = (i == 5);
      step();
    end
    a_start = 1'b0;
    total++; if (a_en !== 1'b0) begin bad++; $display("FAIL start_bit_not_counted_en got=%b exp=0", a_en); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL start_bit_not_counted_busy got=%b exp=1", a_busy); end
    a_din = 1'b0;
    step();
    a_vld = 1'b0;
    total++; if (a_en !== 1'b1) begin bad++; $display("FAIL start_ign_strobe got=%b exp=1", a_en); end
    total++; if (a_dout !== 8'h5A) begin bad++; $display("FAIL start_ign_dout got=%h exp=5a", a_dout); end
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL start_ign_perr got=%b exp=0", a_perr); end
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    total++; if ({a_busy, a_en} !== 2'b00) begin bad++; $display("FAIL start_in_load got=%b exp=00", {a_busy, a_en}); end
    step();
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL start_in_load_idle got=%b exp=0", a_busy); end
  endtask

  task automatic test_abort();
    send_a(8'h3C, 1'b1);
    total++; if (a_dout !== 8'h3C) begin bad++; $display("FAIL abort_pre_dout got=%h exp=3c", a_dout); end
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL abort_pre_perr got=%b exp=1", a_perr); end
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_din = 1'b1;
      a_vld = 1'b1;
      step();
    end
    a_din = 1'b1;
    a_vld = 1'b1;
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    total++; if (a_en !== 1'b0) begin bad++; $display("FAIL abort_no_strobe got=%b exp=0", a_en); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", a_busy); end
    total++; if (a_dout !== 8'h3C) begin bad++; $display("FAIL abort_dout got=%h exp=3c", a_dout); end
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL abort_perr got=%b exp=1", a_perr); end
    step();
    step();
    a_vld = 1'b0;
    a_din = 1'b0;
    total++; if ({a_en, a_busy} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b exp=00", {a_en, a_busy}); end
    total++; if (a_dout !== 8'h3C) begin bad++; $display("FAIL abort_dout_hold got=%h exp=3c", a_dout); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] data;
    data = 8'hA5;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 7; i >= 5; i--) begin
      a_din = data[i];
      a_vld = 1'b1;
      step();
    end
    a_vld = 1'b0;
    a_din = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", a_busy); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", a_busy); end
    total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL rstmid_dout got=%h exp=00", a_dout); end
    total++; if ({a_en, a_perr} !== 2'b00) begin bad++; $display("FAIL rstmid_flags got=%b exp=00", {a_en, a_perr}); end
    step();
    reset = 1'b1;
    step();
    send_a(8'hA5, 1'b0);
    total++; if (a_en !== 1'b1) begin bad++; $display("FAIL rstmid_next_strobe got=%b exp=1", a_en); end
    total++; if (a_dout !== 8'hA5) begin bad++; $display("FAIL rstmid_next_dout got=%h exp=a5", a_dout); end
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL rstmid_next_perr got=%b exp=0", a_perr); end
    step();
  endtask

  initial begin
    test_reset();
    test_frame_msb_par();
    test_parity_error();
    test_lsb_gaps();
    test_start_ignored();
    test_abort();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
